// File: rtl/csr_pwm.sv
// ---------------------------------------------------------------------------
// csr_pwm
//   Multi-channel PWM generator controlled through RISC-V Zicsr style CSR
//   accesses. One free-running counter is shared by all channels; PERIOD and
//   DUTY are double-buffered into shadow registers that are only reloaded at
//   the end of a PWM period (or continuously while disabled), so software
//   updates never produce a truncated or stretched pulse.
//
//   Register map (relative to BaseAddr):
//     +0        CTRL    bit0 EN (rw), bit1 WRAP (sticky, set at each wrap)
//     +1        PERIOD  PWM period minus one
//     +2+i      DUTY[i] high cycles per period for channel i
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous, active-low reset
//   csr_enable  a CSR instruction is executing this cycle
//   csr_addr    CSR address
//   csr_op      funct3: 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI
//   rs1_zimm    rs1 index, or zero-extended immediate for the *I forms
//   rs1_data    rs1 register value
//   match       csr_enable high and csr_addr hits one of our registers
//   out         pre-write value of the addressed register (0 when no match)
//   pwm         registered PWM outputs, one per channel
// ---------------------------------------------------------------------------
module csr_pwm #(
    parameter int          Channels = 4,
    parameter int          CntWidth = 16,
    parameter logic [11:0] BaseAddr = 12'h7C0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                csr_enable,
    input  logic [11:0]         csr_addr,
    input  logic [2:0]          csr_op,
    input  logic [4:0]          rs1_zimm,
    input  logic [31:0]         rs1_data,
    output logic                match,
    output logic [31:0]         out,
    output logic [Channels-1:0] pwm
);

    localparam logic [11:0] NumRegs = 12'(Channels + 2);

    // Architectural registers
    logic                ctrl_en;
    logic                ctrl_wrap;
    logic [CntWidth-1:0] period;
    logic [CntWidth-1:0] duty [Channels];

    // Shadow copies used by the counter/comparators
    logic [CntWidth-1:0] period_sh;
    logic [CntWidth-1:0] duty_sh [Channels];
    logic [CntWidth-1:0] cnt;

    // CSR decode
    logic [11:0]         offset;
    logic [31:0]         rd_val;
    logic [31:0]         src;
    logic [31:0]         new_val;
    logic                wr_en;
    logic                wr_ctrl;
    logic                wr_period;
    logic [Channels-1:0] wr_duty;
    logic                wrap_set;
    logic                disabling;
    logic                unused_new_val;

    // Modular subtraction folds the range check into a single compare.
    assign offset = csr_addr - BaseAddr;
    assign match  = csr_enable && (offset < NumRegs);
    assign out    = match ? rd_val : 32'd0;

    always_comb begin
        rd_val = 32'd0;
        if (offset == 12'd0) begin
            rd_val = {30'd0, ctrl_wrap, ctrl_en};
        end else if (offset == 12'd1) begin
            rd_val = 32'(period);
        end else begin
            for (int i = 0; i < Channels; i++) begin
                if (offset == 12'(i + 2)) begin
                    rd_val = 32'(duty[i]);
                end
            end
        end
    end

    assign src = csr_op[2] ? {27'd0, rs1_zimm} : rs1_data;

    always_comb begin
        case (csr_op[1:0])
            2'b01:   new_val = src;
            2'b10:   new_val = rd_val | src;
            2'b11:   new_val = rd_val & ~src;
            default: new_val = rd_val;
        endcase
    end

    // Set/clear forms with rs1/zimm == 0 are pure reads; funct3 x00 is not a CSR op.
    assign wr_en = match && (csr_op[1:0] != 2'b00)
                 && ((csr_op[1:0] == 2'b01) || (rs1_zimm != 5'd0));

    assign wr_ctrl   = wr_en && (offset == 12'd0);
    assign wr_period = wr_en && (offset == 12'd1);

    always_comb begin
        wr_duty = '0;
        for (int i = 0; i < Channels; i++) begin
            wr_duty[i] = wr_en && (offset == 12'(i + 2));
        end
    end

    // Only the low CntWidth bits are stored; CTRL uses bits [1:0].
    assign unused_new_val = ^new_val;

    assign wrap_set  = ctrl_en && (cnt == period_sh);
    assign disabling = wr_ctrl && !new_val[0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_en   <= 1'b0;
            ctrl_wrap <= 1'b0;
            period    <= '0;
            period_sh <= '0;
            cnt       <= '0;
            pwm       <= '0;
            for (int i = 0; i < Channels; i++) begin
                duty[i]    <= '0;
                duty_sh[i] <= '0;
            end
        end else begin
            // ---- CSR write commit ----
            if (wr_ctrl) begin
                ctrl_en <= new_val[0];
            end
            // A wrap in the same cycle as a software clear wins, so no wrap is lost.
            ctrl_wrap <= wrap_set | (wr_ctrl ? new_val[1] : ctrl_wrap);
            if (wr_period) begin
                period <= new_val[CntWidth-1:0];
            end
            for (int i = 0; i < Channels; i++) begin
                if (wr_duty[i]) begin
                    duty[i] <= new_val[CntWidth-1:0];
                end
            end

            // ---- Counter and PWM output stage ----
            // Shadows see the pre-write PERIOD/DUTY; a write on a wrap edge
            // therefore lands one period later.
            if (!ctrl_en) begin
                cnt       <= '0;
                pwm       <= '0;
                period_sh <= period;
                for (int i = 0; i < Channels; i++) begin
                    duty_sh[i] <= duty[i];
                end
            end else if (disabling) begin
                cnt <= '0;
                pwm <= '0;
            end else begin
                for (int i = 0; i < Channels; i++) begin
                    pwm[i] <= (cnt < duty_sh[i]);
                end
                if (cnt == period_sh) begin
                    cnt       <= '0;
                    period_sh <= period;
                    for (int i = 0; i < Channels; i++) begin
                        duty_sh[i] <= duty[i];
                    end
                end else begin
                    cnt <= cnt + CntWidth'(1);
                end
            end
        end
    end

endmodule
